// File: rtl/pb_timer_array.sv
// Multi-channel down-counter timer array on the KCPSM6 port bus, shared prescaler, W1C interrupt status.
// Latency: register writes act on the strobe edge; data_out is registered one cycle after port_id.
// Backpressure: none; the port bus is always accepted and data_out is 0 outside the block window.
module pb_timer_array #(
    parameter logic [7:0] BASE_ADDRESS = 8'h20,
    parameter int         NUM_TIMERS   = 4,
    parameter int         WIDTH        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] data_in,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] data_out,
    output logic       interrupt
);
    localparam int NB = WIDTH / 8;
    localparam int SW = (WIDTH > 8) ? WIDTH - 8 : 1;

    typedef logic [WIDTH-1:0] word_t;

    logic [7:0] off;
    logic       hit, wr, rd;
    logic [2:0] win, sub;

    // Offset by subtraction so a non-64-aligned base still decodes one contiguous window.
    assign off = port_id - BASE_ADDRESS;
    assign hit = (off[7:6] == 2'b00);
    assign win = off[5:3];
    assign sub = off[2:0];
    assign wr  = write_strobe & hit;
    assign rd  = read_strobe & hit;

    logic [NUM_TIMERS-1:0] pending, mask, en_q, auto_q;
    logic [NUM_TIMERS-1:0] ctrl_wr, step, expire, w1c;
    word_t                 load_q  [NUM_TIMERS];
    word_t                 count_q [NUM_TIMERS];
    logic [SW-1:0]         snap_q  [NUM_TIMERS];
    logic [7:0]            prescale, psc_cnt;
    logic                  tick;
    logic [7:0]            rd_dat;

    always_comb begin
        tick = (psc_cnt == prescale);
        w1c  = (wr && off == 8'd0) ? data_in[NUM_TIMERS-1:0] : '0;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            ctrl_wr[n] = wr && (win == 3'(n + 1)) && (sub == 3'd4);
            // A stopping CTRL write beats a tick in the same cycle.
            step[n]    = en_q[n] && tick && !(ctrl_wr[n] && !data_in[0]);
            expire[n]  = step[n] && (count_q[n] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            psc_cnt  <= '0;
            mask     <= '0;
            pending  <= '0;
        end else begin
            if (wr && off == 8'd2) begin
                prescale <= data_in;
                psc_cnt  <= '0;
            end else if (tick) begin
                psc_cnt  <= '0;
            end else begin
                psc_cnt  <= psc_cnt + 8'd1;
            end
            if (wr && off == 8'd1)
                mask <= data_in[NUM_TIMERS-1:0];
            pending <= (pending & ~w1c) | expire;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q   <= '0;
            auto_q <= '0;
            for (int n = 0; n < NUM_TIMERS; n++) begin
                load_q[n]  <= '0;
                count_q[n] <= '0;
                snap_q[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_TIMERS; n++) begin
                if (wr && win == 3'(n + 1)) begin
                    for (int b = 0; b < NB; b++)
                        if (sub == 3'(b))
                            load_q[n][8*b +: 8] <= data_in;
                end
                // Byte 0 is returned live on the same edge, so only the upper bytes are held.
                if (rd && win == 3'(n + 1) && sub == 3'd0)
                    snap_q[n] <= SW'(count_q[n] >> 8);
                if (ctrl_wr[n]) begin
                    auto_q[n] <= data_in[1];
                    if (!data_in[0]) begin
                        en_q[n] <= 1'b0;
                    end else if (!en_q[n]) begin
                        en_q[n]    <= 1'b1;
                        count_q[n] <= load_q[n];
                    end
                end
                if (step[n]) begin
                    if (count_q[n] != '0)
                        count_q[n] <= count_q[n] - word_t'(1);
                    else if (ctrl_wr[n] ? data_in[1] : auto_q[n])
                        count_q[n] <= load_q[n];
                    else
                        en_q[n] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        if (hit) begin
            if (win == 3'd0) begin
                case (sub)
                    3'd0:    rd_dat[NUM_TIMERS-1:0] = pending;
                    3'd1:    rd_dat[NUM_TIMERS-1:0] = mask;
                    3'd2:    rd_dat = prescale;
                    default: rd_dat = '0;
                endcase
            end
            for (int n = 0; n < NUM_TIMERS; n++) begin
                if (win == 3'(n + 1)) begin
                    if (sub == 3'd0) begin
                        rd_dat = count_q[n][7:0];
                    end else if (sub == 3'd4) begin
                        rd_dat = {6'b0, auto_q[n], en_q[n]};
                    end else begin
                        for (int b = 1; b < NB; b++)
                            if (sub == 3'(b))
                                rd_dat = snap_q[n][8*(b-1) +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            data_out <= '0;
        else
            data_out <= rd_dat;
    end

    assign interrupt = |(pending & mask);

endmodule

// File: doc/pb_timer_array.md
Name: pb_timer_array

Overview:
- Multi-channel, parametrised successor to the single PicoBlaze port-mapped timer.
- Provides NUM_TIMERS independent down-counters of WIDTH bits. All channels share one programmable prescaler.
- Per-channel one-shot or auto-reload mode, a sticky interrupt-pending register with write-1-to-clear, and a mask.
- Sits on the KCPSM6 port bus next to the display peripheral. Its data_out is ORed into in_port; its interrupt drives the CPU interrupt input.

Parameters:
- BASE_ADDRESS, 8'h20, first port address of the block; must be 64-aligned.
- NUM_TIMERS, 4, channel count; legal 1..7.
- WIDTH, 16, counter/load width in bits; legal 8, 16, 24, 32.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- port_id, input, 8, CPU port address.
- data_in, input, 8, CPU write data (out_port).
- write_strobe, input, 1, CPU write qualifier.
- read_strobe, input, 1, CPU read qualifier.
- data_out, output, 8, registered read data; 0 when not addressed.
- interrupt, output, 1, OR of (pending & mask).

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-low.
- Reset values: all registers and counters 0, data_out=0, interrupt=0, prescale counter 0.
- Register map (offsets from BASE_ADDRESS):
  - +0 STATUS: bit n = pending of channel n; read; write 1 clears.
  - +1 MASK: bit n enables channel n interrupt; R/W.
  - +2 PRESCALE: 8-bit; R/W.
  - Channel n window at +8*(n+1):
    - +0..+3: write = LOAD bytes, little-endian; read = COUNT snapshot bytes. Bytes at and above WIDTH/8 are ignored on write and read as 0.
    - +4 CTRL: bit0 EN, bit1 AUTO; R/W; other bits read 0.
  - Unmapped offsets in the 64-byte window read 0 and ignore writes.
- Bus timing:
  - Writes take effect on the clk edge where write_strobe=1 and port_id matches.
  - data_out is registered from port_id decode every cycle, so it is valid one cycle after port_id settles, matching PicoBlaze INPUT timing.
  - data_out=0 whenever port_id is outside the block.
- Snapshot:
  - A read_strobe at channel offset +0 copies the full live COUNT into that channel's snapshot register on that edge.
  - The +0 read itself returns the live byte 0, equal to snapshot byte 0.
  - Reads of +1..+3 return the snapshot, so multi-byte reads are coherent.
- Prescaler:
  - 8-bit counter runs continuously.
  - When it equals PRESCALE, tick=1 for one cycle and the counter returns to 0. Tick period = PRESCALE+1 clocks; PRESCALE=0 ticks every clock.
  - Writing PRESCALE resets the prescale counter to 0.
- Channel states IDLE (EN=0) and RUN (EN=1):
  - IDLE→RUN: a CTRL write with EN going 0→1 loads COUNT<=LOAD that cycle.
  - A CTRL write with EN=1 while already running changes AUTO only; no reload.
  - RUN, tick, COUNT≠0: COUNT<=COUNT-1.
  - RUN, tick, COUNT==0: pending[n]<=1. If AUTO, COUNT<=LOAD and stay in RUN; else EN<=0 and COUNT holds 0 (IDLE).
  - Expiry period = (LOAD+1) ticks. LOAD=0 with AUTO expires on every tick.
  - A CTRL write with EN=0 stops the channel immediately. COUNT holds its value and pending is unchanged.
  - Writing LOAD while running does not disturb COUNT; the new value applies at the next reload or enable.
- Simultaneous events:
  - Expiry and a STATUS W1C on the same bit in the same cycle: set wins, pending stays 1.
  - Expiry and a CTRL EN=0 write in the same cycle: the write wins, no pending set.
  - Channels are fully independent; several may expire on the same tick.
- interrupt: combinational OR of (pending & MASK) over the channels; level, held until cleared.
- Mid-operation reset: asynchronous assertion returns everything to reset values within the same cycle. Nothing resumes after deassertion until the CPU rewrites CTRL.

Test Plan:
- Reset: release reset, read all mapped registers → all 0, interrupt=0.
- One-shot, 16-bit: PRESCALE=0, ch0 LOAD=0x0005, MASK=1, CTRL=0x01 → interrupt rises exactly 6 clocks after the CTRL write edge; CTRL reads 0x00; COUNT reads 0; STATUS=0x01; write STATUS=0x01 → interrupt=0.
- Auto-reload with prescale: PRESCALE=3, ch1 LOAD=2, CTRL=0x03 → pending[1] sets every 12 clocks; W1C issued in the same cycle as an expiry leaves STATUS bit1=1.
- Snapshot coherence: WIDTH=32, LOAD=0x00000100, running with PRESCALE=0; read +0 then +1 across the 0x100→0xFF roll → the bytes returned match the snapshot value (0x00,0x01 or 0xFF,0x00), never mixed.
- Masking and multi-channel: ch0 and ch2 expire on the same tick with MASK=0x04 → STATUS=0x05, interrupt=1; clear bit2 → interrupt=0 while STATUS=0x01.
- Async reset mid-count: assert reset at COUNT=3 → data_out, interrupt and COUNT are 0 immediately; after release, no expiry occurs without a new CTRL write.
